// File: rtl/prv_trap_ctrl_if.sv
// Trap controller bus: event inputs from the pipeline, redirect outputs back.
// Master drives events; slave (the controller) drives redirect and CSR values.
interface prv_trap_ctrl_if #(
    parameter int NUM_EXT = 4
);
    logic [9:0]         exc;
    logic               ret;
    logic               pipe_clear;
    logic [31:0]        curr_epc;
    logic               timer_int;
    logic               soft_int;
    logic [NUM_EXT-1:0] ext_int;
    logic               mie_global;
    logic [31:0]        mtvec;
    logic [31:0]        npc;
    logic               insert_pc;
    logic               intr;
    logic [31:0]        mepc;
    logic [31:0]        mcause;
    logic [NUM_EXT-1:0] ext_claim;

    modport master (
        output exc, ret, pipe_clear, curr_epc, timer_int, soft_int,
        output ext_int, mie_global, mtvec,
        input  npc, insert_pc, intr, mepc, mcause, ext_claim
    );

    modport slave (
        input  exc, ret, pipe_clear, curr_epc, timer_int, soft_int,
        input  ext_int, mie_global, mtvec,
        output npc, insert_pc, intr, mepc, mcause, ext_claim
    );
endinterface

// File: rtl/prv_trap_ctrl.sv
// Trap/interrupt controller: IDLE -> DRAIN -> REDIRECT sequencing of traps and mret.
// Define PRV_VECTORED_TRAP_EN for vectored interrupt targets (mtvec base + 4*code).
module prv_trap_ctrl #(
    parameter int NUM_EXT = 4
) (
    input logic            CLK,
    input logic            nRST,
    prv_trap_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRAIN, REDIR} state_t;

    state_t             state, state_d;
    logic [NUM_EXT-1:0] ext_prev, pending, rise, take, claim_now;
    logic               exc_any, irq_any, go;
    logic [4:0]         exc_code, irq_code, code_sel;
    logic               ev_intr, ev_ret, ev_intr_d, ev_ret_d;
    logic [31:0]        base, tgt;
    logic [31:0]        npc_d, mepc_d, mcause_d;
    logic               insert_d, intr_d;
    logic [NUM_EXT-1:0] claim_d;
    logic               unused_bits;

    assign unused_bits = ^{bus.exc[0], bus.mtvec[1:0]};
    assign base        = {bus.mtvec[31:2], 2'b00};
    assign rise        = bus.ext_int & ~ext_prev;
    assign exc_any     = |bus.exc[9:1];
    assign irq_any     = bus.mie_global &
                         ((|pending) | bus.soft_int | bus.timer_int);
    assign go          = exc_any | bus.ret | irq_any;
    assign claim_now   = (state == IDLE && !exc_any && bus.mie_global)
                         ? take : '0;

    // Fixed-priority cause selection for exceptions and interrupts.
    always_comb begin
        exc_code = 5'd0;
        if      (bus.exc[8]) exc_code = 5'd3;
        else if (bus.exc[1]) exc_code = 5'd1;
        else if (bus.exc[2]) exc_code = 5'd0;
        else if (bus.exc[3]) exc_code = 5'd2;
        else if (bus.exc[9]) exc_code = 5'd11;
        else if (bus.exc[7]) exc_code = 5'd6;
        else if (bus.exc[6]) exc_code = 5'd7;
        else if (bus.exc[5]) exc_code = 5'd4;
        else if (bus.exc[4]) exc_code = 5'd5;
        take     = '0;
        irq_code = 5'd0;
        if (|pending) begin
            for (int i = NUM_EXT - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    take     = '0;
                    take[i]  = 1'b1;
                    irq_code = 5'd16 + 5'(i);
                end
            end
        end else if (bus.soft_int) begin
            irq_code = 5'd3;
        end else if (bus.timer_int) begin
            irq_code = 5'd7;
        end
        code_sel = exc_any ? exc_code : irq_code;
    end

    // Trap target; mepc is only used for mret.
    always_comb begin
`ifdef PRV_VECTORED_TRAP_EN
        tgt = base + (ev_intr ? {25'd0, bus.mcause[4:0], 2'b00} : 32'd0);
`else
        tgt = base;
`endif
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (go) state_d = DRAIN;
            DRAIN:   if (bus.pipe_clear) state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the event latch.
    always_comb begin
        npc_d     = bus.npc;
        mepc_d    = bus.mepc;
        mcause_d  = bus.mcause;
        insert_d  = 1'b0;
        intr_d    = 1'b0;
        claim_d   = '0;
        ev_intr_d = ev_intr;
        ev_ret_d  = ev_ret;
        if (state == IDLE && go) begin
            ev_ret_d  = !exc_any && !irq_any;
            ev_intr_d = !exc_any && irq_any;
            claim_d   = claim_now;
            if (!ev_ret_d) begin
                mepc_d   = bus.curr_epc;
                mcause_d = {ev_intr_d, 26'd0, code_sel};
            end
        end
        if (state == DRAIN && bus.pipe_clear) begin
            insert_d = 1'b1;
            intr_d   = ev_intr;
            npc_d    = ev_ret ? bus.mepc : tgt;
        end
    end

    // Output and event registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.npc       <= '0;
            bus.insert_pc <= 1'b0;
            bus.intr      <= 1'b0;
            bus.mepc      <= '0;
            bus.mcause    <= '0;
            bus.ext_claim <= '0;
            ev_intr       <= 1'b0;
            ev_ret        <= 1'b0;
        end else begin
            bus.npc       <= npc_d;
            bus.insert_pc <= insert_d;
            bus.intr      <= intr_d;
            bus.mepc      <= mepc_d;
            bus.mcause    <= mcause_d;
            bus.ext_claim <= claim_d;
            ev_intr       <= ev_intr_d;
            ev_ret        <= ev_ret_d;
        end
    end

    // Sticky external pending; a new edge wins over a simultaneous claim.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ext_prev <= '0;
            pending  <= '0;
        end else begin
            ext_prev <= bus.ext_int;
            pending  <= (pending & ~claim_now) | rise;
        end
    end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Scoreboard bench for prv_trap_ctrl: directed trap, interrupt, mret and reset cases.
// Expected redirects are queued by stimulus and checked by a monitor on insert_pc.
module tb_prv_trap_ctrl;

    typedef struct {
        logic [31:0] npc;
        logic        intr;
        logic [31:0] mepc;
        logic [31:0] mcause;
        int          cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    prv_trap_ctrl_if #(.NUM_EXT(4)) bus();

    prv_trap_ctrl #(.NUM_EXT(4)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [31:0] npc, input logic intr,
                        input logic [31:0] mepc, input logic [31:0] mcause,
                        input int c);
        exp_t e;
        e.npc = npc; e.intr = intr; e.mepc = mepc;
        e.mcause = mcause; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: every insert_pc pulse must match the oldest expected redirect.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && bus.insert_pc === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_insert", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("npc", bus.npc, e.npc);
                chk("intr", {31'd0, bus.intr}, {31'd0, e.intr});
                chk("mepc", bus.mepc, e.mepc);
                chk("mcause", bus.mcause, e.mcause);
                if (e.cyc >= 0) chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_claim(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.ext_claim != 0) break;
            @(negedge CLK);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_npc"}, bus.npc, 32'd0);
        chk({tag, "_insert"}, {31'd0, bus.insert_pc}, 32'd0);
        chk({tag, "_intr"}, {31'd0, bus.intr}, 32'd0);
        chk({tag, "_mepc"}, bus.mepc, 32'd0);
        chk({tag, "_mcause"}, bus.mcause, 32'd0);
        chk({tag, "_claim"}, {28'd0, bus.ext_claim}, 32'd0);
    endtask

    logic [31:0] v_ext1, v_ext2, v_tmr;
    int k;

    initial begin
`ifdef PRV_VECTORED_TRAP_EN
        v_ext1 = 32'h244; v_ext2 = 32'h248; v_tmr = 32'h101C;
`else
        v_ext1 = 32'h200; v_ext2 = 32'h200; v_tmr = 32'h1000;
`endif
        bus.exc = '0; bus.ret = 0; bus.pipe_clear = 1;
        bus.curr_epc = '0; bus.timer_int = 0; bus.soft_int = 0;
        bus.ext_int = '0; bus.mie_global = 0; bus.mtvec = 32'h200;
        nclk(2);
        chk_zero_outputs("reset");
        nRST = 1'b1;
        nclk(2);

        // illegal instruction, pipeline already clear
        bus.exc[3] = 1'b1; bus.curr_epc = 32'h100;
        push(32'h200, 0, 32'h100, 32'd2, cyc + 2);
        nclk(1); bus.exc = '0;
        nclk(5);

        // breakpoint + mal_l + ret together: breakpoint wins, no mret
        bus.exc[8] = 1'b1; bus.exc[5] = 1'b1; bus.ret = 1'b1;
        bus.curr_epc = 32'h120;
        push(32'h200, 0, 32'h120, 32'd3, cyc + 2);
        nclk(1); bus.exc = '0; bus.ret = 0;
        nclk(6);

        // two external lines rise together: line 1 first, then line 2
        bus.mie_global = 1; bus.curr_epc = 32'h300;
        bus.ext_int = 4'b0110;
        push(v_ext1, 1, 32'h300, 32'h8000_0011, cyc + 3);
        push(v_ext2, 1, 32'h300, 32'h8000_0012, -1);
        nclk(1);
        wait_claim(6);
        chk("claim_first", {28'd0, bus.ext_claim}, 32'h2);
        nclk(1);
        wait_claim(8);
        chk("claim_second", {28'd0, bus.ext_claim}, 32'h4);
        nclk(5);
        bus.ext_int = '0;
        nclk(2);

        // timer interrupt; mtvec low bits must be ignored
        bus.mtvec = 32'h1003; bus.timer_int = 1; bus.curr_epc = 32'h400;
        push(v_tmr, 1, 32'h400, 32'h8000_0007, cyc + 2);
        nclk(1); bus.timer_int = 0;
        nclk(5);
        bus.mie_global = 0; bus.mtvec = 32'h200;

        // load-fault sets mepc to 0x344, then mret with slow drain
        bus.exc[4] = 1'b1; bus.curr_epc = 32'h344;
        push(32'h200, 0, 32'h344, 32'd5, cyc + 2);
        nclk(1); bus.exc = '0;
        nclk(5);
        bus.pipe_clear = 0; bus.ret = 1; bus.curr_epc = 32'h999;
        k = cyc;
        push(32'h344, 0, 32'h344, 32'd5, k + 6);
        nclk(1); bus.ret = 0;
        nclk(4);
        bus.pipe_clear = 1;
        nclk(5);

        // reset while draining aborts the trap
        bus.pipe_clear = 0; bus.exc[3] = 1'b1; bus.curr_epc = 32'h500;
        nclk(1); bus.exc = '0;
        nRST = 1'b0;
        #1;
        chk_zero_outputs("abort");
        nclk(1);
        nRST = 1'b1; bus.pipe_clear = 1;
        nclk(6);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
